// File: rtl/alu_result_display.sv
`default_nettype none
// ============================================================================
// alu_result_display: captures a signed ALU result, converts its magnitude to
// BCD by sequential double-dabble and scans it onto a 4-digit 7-seg display.
// Revision: 1.0
// ============================================================================
module alu_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [8:0] RESULT,
  input  logic       OF,
  output logic       BUSY,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam logic [15:0] C_REFRESH_TERM = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  C_SEG_BLANK    = 7'b1111111;
  localparam logic [6:0]  C_SEG_DASH     = 7'b0111111;
  localparam logic [6:0]  C_SEG_E        = 7'b0000110;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        of_q, of_d;
  logic [11:0] disp_bcd_q, disp_bcd_d;
  logic        disp_neg_q, disp_neg_d;
  logic        disp_of_q, disp_of_d;
  logic        busy_q, busy_d;
  logic [15:0] refresh_q, refresh_d;
  logic [1:0]  scan_q, scan_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [11:0] adj;
  logic [11:0] shifted;
  logic [3:0]  hund, tens, units;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return C_SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    of_d       = of_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    disp_of_d  = disp_of_q;
    adj        = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[10:0], mag_q[8]};

    case (state_q)
      IDLE: begin
        if (LOAD) begin
          // 9-bit negate maps -256 onto unsigned 256
          mag_d   = RESULT[8] ? (~RESULT + 9'd1) : RESULT;
          neg_d   = RESULT[8];
          of_d    = OF;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = shifted;
        mag_d = {mag_q[7:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          disp_bcd_d = shifted;
          disp_neg_d = neg_q;
          disp_of_d  = of_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CONVERT);
  end

  always_comb begin
    hund  = disp_bcd_q[11:8];
    tens  = disp_bcd_q[7:4];
    units = disp_bcd_q[3:0];

    if (refresh_q == C_REFRESH_TERM) begin
      refresh_d = '0;
      scan_d    = scan_q + 2'd1;
    end else begin
      refresh_d = refresh_q + 16'd1;
      scan_d    = scan_q;
    end

    an_d = ~(4'b0001 << scan_q);
    case (scan_q)
      2'd0:    seg_d = seg_of(units);
      2'd1:    seg_d = (hund == 4'd0 && tens == 4'd0) ? C_SEG_BLANK : seg_of(tens);
      2'd2:    seg_d = (hund == 4'd0) ? C_SEG_BLANK : seg_of(hund);
      default: seg_d = disp_of_q ? C_SEG_E : (disp_neg_q ? C_SEG_DASH : C_SEG_BLANK);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      of_q       <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_of_q  <= 1'b0;
      busy_q     <= 1'b0;
      refresh_q  <= '0;
      scan_q     <= '0;
      an_q       <= 4'b1111;
      seg_q      <= C_SEG_BLANK;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      of_q       <= of_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      disp_of_q  <= disp_of_d;
      busy_q     <= busy_d;
      refresh_q  <= refresh_d;
      scan_q     <= scan_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign BUSY = busy_q;
  assign AN   = an_q;
  assign SEG  = seg_q;
  assign DP   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ============================================================================
// tb_alu_result_display: randomized and directed bench for alu_result_display
// against a decimal-arithmetic display model. Revision: 1.0
// ============================================================================
module tb_alu_result_display;

  localparam int REFRESH_DIV = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD = 1'b0;
  logic [8:0] RESULT = '0;
  logic       OF = 1'b0;
  logic       BUSY;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  logic [8:0] m_r  = '0;
  logic       m_of = 1'b0;

  alu_result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .RESULT(RESULT), .OF(OF),
    .BUSY(BUSY), .AN(AN), .SEG(SEG), .DP(DP)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edges <= RST ? 0 : edges + 1;

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input logic [8:0] r, input logic of);
    int v, mag;
    v   = r[8] ? int'(r) - 512 : int'(r);
    mag = (v < 0) ? -v : v;
    case (idx)
      0:       return digit_code(mag % 10);
      1:       return (mag < 10)  ? 7'b1111111 : digit_code((mag / 10) % 10);
      2:       return (mag < 100) ? 7'b1111111 : digit_code(mag / 100);
      default: return of ? 7'b0000110 : ((v < 0) ? 7'b0111111 : 7'b1111111);
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    logic [3:0] a;
    a = 4'b1111;
    a[idx] = 1'b0;
    return a;
  endfunction

  function automatic int cur_idx();
    return ((edges - 1) / REFRESH_DIV) % 4;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (AN !== 4'b1111 || SEG !== 7'b1111111 || BUSY !== 1'b0 || DP !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: AN=%b SEG=%b BUSY=%b DP=%b required 1111 1111111 0 1", AN, SEG, BUSY, DP);
      end
    end
    RST = 1'b0;
    m_r = '0; m_of = 1'b0;
    for (int k = 0; k < 4 * REFRESH_DIV + 2; k++) begin
      @(negedge CLK);
      checks++;
      if (AN !== exp_an(cur_idx()) || SEG !== exp_seg(cur_idx(), m_r, m_of) || BUSY !== 1'b0 || DP !== 1'b1) begin
        errors++;
        $display("FAIL reset_scan: edge %0d AN=%b SEG=%b BUSY=%b required %b %b 0", edges, AN, SEG, BUSY,
                 exp_an(cur_idx()), exp_seg(cur_idx(), m_r, m_of));
      end
    end
  endtask

  task automatic test_conversion(input logic [8:0] r, input logic of);
    @(negedge CLK);
    RESULT = r; OF = of; LOAD = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      if (k == 0) begin LOAD = 1'b0; RESULT = 9'($urandom); OF = 1'($urandom); end
      checks++;
      if (BUSY !== 1'b1) begin
        errors++;
        $display("FAIL conv_busy: r=%h cycle %0d BUSY=%b required 1", r, k, BUSY);
      end
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || SEG !== exp_seg(cur_idx(), m_r, m_of)) begin
      errors++;
      $display("FAIL conv_hold: r=%h BUSY=%b SEG=%b required 0 %b", r, BUSY, SEG, exp_seg(cur_idx(), m_r, m_of));
    end
    m_r = r; m_of = of;
    @(negedge CLK);
    checks++;
    if (SEG !== exp_seg(cur_idx(), m_r, m_of)) begin
      errors++;
      $display("FAIL conv_latency: r=%h SEG=%b required %b", r, SEG, exp_seg(cur_idx(), m_r, m_of));
    end
    for (int k = 0; k < 4 * REFRESH_DIV; k++) begin
      @(negedge CLK);
      checks++;
      if (AN !== exp_an(cur_idx()) || SEG !== exp_seg(cur_idx(), m_r, m_of)) begin
        errors++;
        $display("FAIL conv_scan: r=%h of=%b AN=%b SEG=%b required %b %b", r, of, AN, SEG,
                 exp_an(cur_idx()), exp_seg(cur_idx(), m_r, m_of));
      end
    end
  endtask

  task automatic test_collision();
    @(negedge CLK);
    RESULT = 9'd125; OF = 1'b0; LOAD = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b1) begin
        errors++;
        $display("FAIL collision_busy: cycle %0d BUSY=%b required 1", k, BUSY);
      end
      if (k == 0) LOAD = 1'b0;
      if (k == 2) begin LOAD = 1'b1; RESULT = 9'd42; end
      if (k == 3) LOAD = 1'b0;
    end
    m_r = 9'd125; m_of = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 4 * REFRESH_DIV; k++) begin
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || AN !== exp_an(cur_idx()) || SEG !== exp_seg(cur_idx(), m_r, m_of)) begin
        errors++;
        $display("FAIL collision_display: BUSY=%b AN=%b SEG=%b required 0 %b %b", BUSY, AN, SEG,
                 exp_an(cur_idx()), exp_seg(cur_idx(), m_r, m_of));
      end
    end
    test_conversion(9'd42, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [8:0] a, b;
    logic       busy_exp;
    a = 9'($urandom); b = 9'($urandom);
    @(negedge CLK);
    RESULT = a; OF = 1'b0; LOAD = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (k == 0) RESULT = b;
      if (k == 10) begin m_r = a; m_of = 1'b0; end
      busy_exp = !(k == 9 || k == 19);
      checks++;
      if (BUSY !== busy_exp) begin
        errors++;
        $display("FAIL b2b_busy: cycle %0d BUSY=%b required %b", k, BUSY, busy_exp);
      end
      if (k >= 10) begin
        checks++;
        if (SEG !== exp_seg(cur_idx(), m_r, m_of)) begin
          errors++;
          $display("FAIL b2b_first: a=%h SEG=%b required %b", a, SEG, exp_seg(cur_idx(), m_r, m_of));
        end
      end
      if (k == 10) LOAD = 1'b0;
    end
    m_r = b;
    for (int k = 0; k < 4 * REFRESH_DIV; k++) begin
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || SEG !== exp_seg(cur_idx(), m_r, m_of)) begin
        errors++;
        $display("FAIL b2b_second: b=%h BUSY=%b SEG=%b required 0 %b", b, BUSY, SEG, exp_seg(cur_idx(), m_r, m_of));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    RESULT = 9'h160; OF = 1'b0; LOAD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 0) LOAD = 1'b0;
      checks++;
      if (BUSY !== 1'b1) begin
        errors++;
        $display("FAIL midrst_busy: cycle %0d BUSY=%b required 1", k, BUSY);
      end
    end
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || AN !== 4'b1111 || SEG !== 7'b1111111) begin
        errors++;
        $display("FAIL midrst_during: BUSY=%b AN=%b SEG=%b required 0 1111 1111111", BUSY, AN, SEG);
      end
    end
    RST = 1'b0;
    m_r = '0; m_of = 1'b0;
    for (int k = 0; k < 6 * REFRESH_DIV; k++) begin
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || AN !== exp_an(cur_idx()) || SEG !== exp_seg(cur_idx(), m_r, m_of)) begin
        errors++;
        $display("FAIL midrst_after: BUSY=%b AN=%b SEG=%b required 0 %b %b", BUSY, AN, SEG,
                 exp_an(cur_idx()), exp_seg(cur_idx(), m_r, m_of));
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversion(9'd125, 1'b0);
    test_conversion(9'h160, 1'b0);
    test_conversion(9'h100, 1'b0);
    test_conversion(9'h1FF, 1'b0);
    test_conversion(9'h0A0, 1'b1);
    test_conversion(9'd7,   1'b0);
    test_conversion(9'd0,   1'b0);
    test_conversion(9'd255, 1'b0);
    for (int i = 0; i < 10; i++) begin
      test_conversion(9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0));
    end
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream consumer of the ALU arithmetic units, including the x5 multiplier stage, which supply a 9-bit signed result and an overflow flag.
- On a load strobe it captures the result and overflow flag and converts the magnitude to 3 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- It drives a 4-digit, active-low, multiplexed 7-segment display showing sign/error, hundreds, tens and units.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays enabled before the scan advances; legal range 2..65535.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- LOAD  input  1  capture strobe; sampled only when idle.
- RESULT  input  9  two's-complement result, range -256..255.
- OF  input  1  overflow flag accompanying RESULT.
- BUSY  output  1  high while a conversion is in progress.
- AN  output  4  active-low digit enables. AN[0]=units, AN[1]=tens, AN[2]=hundreds, AN[3]=sign/error.
- SEG  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- DP  output  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (RST=1 at an edge):
  - State returns to IDLE; BUSY=0.
  - Displayed value becomes +0 with no error; AN=4'b1111; SEG=7'b1111111; DP=1.
  - Scan index and refresh counter are cleared to 0.
  - Reset mid-conversion abandons the conversion, and the display shows the reset value.
- Reset release:
  - On the first edge with RST=0, AN=4'b1110 and SEG shows units "0".
  - All outputs are registered.
- FSM, IDLE:
  - If LOAD=1, capture RESULT and OF.
  - Magnitude is the 9-bit unsigned two's-complement absolute value (-256 -> 256). The sign bit is RESULT[8].
  - Next state CONVERT; BUSY=1 from the next cycle.
- FSM, CONVERT:
  - Exactly 9 shift cycles: each cycle add 3 to any BCD nibble >=5, then shift left by 1, feeding magnitude bits MSB first.
  - On the 9th cycle the BCD result, sign and captured OF are written to the display registers. State returns to IDLE and BUSY=0 on the following cycle.
  - New digits appear on SEG 10 edges after the LOAD sample edge.
- LOAD while BUSY=1 is ignored, with no queuing. LOAD held high in IDLE starts back-to-back conversions.
- Until a conversion completes, the display registers keep the previous value, so there is no partial update.
- Digit contents:
  - Units always shown.
  - Tens blanked if hundreds=0 and tens=0.
  - Hundreds blanked if 0.
  - Sign digit shows 'E' if the captured OF=1 (precedence), else '-' if negative, else blank.
- Segment codes ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, 'E'=0000110, blank=1111111
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0 and the scan index increments modulo 4 (0->1->2->3->0).
  - Exactly one AN bit is low at any time after reset, and SEG always matches the enabled digit.
  - Scanning continues unaffected during conversions and LOAD.

Test Plan:
- Reset/scan: REFRESH_DIV=4, hold RST 3 cycles, release -> AN sequence 1110,1101,1011,0111 with each held 4 cycles. SEG: units 1000000, then blank for tens, hundreds and sign. BUSY=0.
- Positive: LOAD pulse with RESULT=9'd125, OF=0 -> BUSY high for 9 cycles. On the 10th edge the digits read sign blank, 1, 2, 5 (SEG 1111001, 0100100, 0010010).
- Negative extremes:
  - RESULT=9'h160 (-160) -> '-',1,6,0.
  - RESULT=9'h100 (-256) -> '-',2,5,6.
  - RESULT=9'h1FF (-1) -> '-', blank, blank, 1.
- Overflow and blanking:
  - RESULT=9'h0A0, OF=1 -> 'E' (0000110),1,6,0.
  - RESULT=9'd7, OF=0 -> blank, blank, blank, 7.
- LOAD collision: load 125, then 3 cycles later load 9'd42 while BUSY -> display ends at 125 and BUSY deasserts after 9 cycles. A later load of 42 in IDLE -> blank, blank, 4, 2.
- Reset mid-operation: load -160, assert RST in the 5th CONVERT cycle -> BUSY=0 and AN=1111 during reset. After release the display shows units "0", never 160.
